// File: rtl/cache_control_pkg.sv
// Shared types and geometry for the 2-way, 8-set, 32-byte-line cache controller.
package cache_types;

    localparam int unsigned TAG_W       = 24;
    localparam int unsigned SET_W       = 3;
    localparam int unsigned OFFSET_W    = 5;
    localparam int unsigned NUM_WAYS    = 2;
    localparam int unsigned WAY_W       = $clog2(NUM_WAYS);
    localparam int unsigned LINE_ADDR_W = TAG_W + SET_W + OFFSET_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        RESOLVE   = 2'd3
    } state_t;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter used for the performance-debug counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM: hit/miss decision, victim writeback before fill, datapath
// load enables, LRU update, pmem address select and performance counters.
module cache_control
    import cache_types::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               hit_0,
    input  logic               hit_1,
    input  logic               dirty_0,
    input  logic               dirty_1,
    input  logic               lru,
    input  logic               pmem_resp,
    output logic               mem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic               pmem_addr_sel,
    output logic               way_sel,
    output logic               load_data,
    output logic               load_tag,
    output logic               load_valid,
    output logic               set_dirty,
    output logic               clear_dirty,
    output logic               data_in_sel,
    output logic               load_lru,
    output logic               lru_in,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [COUNT_W-1:0] wb_count
);

    state_t           state;
    state_t           state_next;
    logic             req;
    logic             is_write;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_dirty;
    logic             hit_inc;
    logic             miss_inc;
    logic             wb_inc;

    assign req          = mem_read | mem_write;
    assign is_write     = mem_write;
    assign hit          = hit_0 | hit_1;
    assign hit_way      = WAY_W'(hit_1);
    assign victim_way   = WAY_W'(lru);
    assign victim_dirty = lru ? dirty_1 : dirty_0;

    // State register; synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Mealy outputs; everything forced low while in reset.
    always_comb begin
        state_next    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        set_dirty     = 1'b0;
        clear_dirty   = 1'b0;
        data_in_sel   = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;

        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        hit_inc  = 1'b1;
                        if (is_write) begin
                            load_data   = 1'b1;
                            data_in_sel = 1'b1;
                            set_dirty   = 1'b1;
                        end
                    end else if (req) begin
                        miss_inc   = 1'b1;
                        state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end

                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = victim_way;
                    if (pmem_resp) begin
                        wb_inc     = 1'b1;
                        state_next = ALLOCATE;
                    end
                end

                ALLOCATE: begin
                    pmem_read = 1'b1;
                    way_sel   = victim_way;
                    if (pmem_resp) begin
                        load_data   = 1'b1;
                        load_tag    = 1'b1;
                        load_valid  = 1'b1;
                        clear_dirty = 1'b1;
                        state_next  = RESOLVE;
                    end
                end

                RESOLVE: begin
                    // A dropped request gets no response and no array writes.
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (is_write) begin
                            load_data   = 1'b1;
                            data_in_sel = 1'b1;
                            set_dirty   = 1'b1;
                        end
                    end
                    state_next = IDLE;
                end

                default: state_next = IDLE;
            endcase
        end
    end

    sat_counter #(.W(COUNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(COUNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );

    sat_counter #(.W(COUNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wb_inc),
        .count (wb_count)
    );

endmodule
